wb_commit_arbiter: RTL and testbench

Orders and issues write-backs from the two WBU ways into the dual-write-port integer register file. Each way hands over one result at a time with a 2-bit pID; way0 carries even pIDs (00, 10), way1 odd pIDs (01, 11). The block buffers one entry per way and commits in strict program order 00→01→10→11→00, up to two per cycle. It drives registered write ports into the RegFile and back-pressures each way.

---
 rtl/wb_commit_arbiter_if.sv | 53 +++++
 rtl/wb_commit_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_commit_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_arbiter_if.sv
// Bundle of the two WBU write-back ways, the dual RegFile write ports and the
// status/flush signals that connect to wb_commit_arbiter.
interface wb_commit_if;
  logic        flush_i;

  logic        way0_valid_i;
  logic        way0_rdWriteEnable_i;
  logic [4:0]  way0_rdAddr_i;
  logic [63:0] way0_rdData_i;
  logic [1:0]  way0_pID_i;
  logic        way0_ready_o;

  logic        way1_valid_i;
  logic        way1_rdWriteEnable_i;
  logic [4:0]  way1_rdAddr_i;
  logic [63:0] way1_rdData_i;
  logic [1:0]  way1_pID_i;
  logic        way1_ready_o;

  logic        port0_we_o;
  logic [4:0]  port0_addr_o;
  logic [63:0] port0_data_o;
  logic        port1_we_o;
  logic [4:0]  port1_addr_o;
  logic [63:0] port1_data_o;

  logic [1:0]  expPID_o;
  logic        err_o;

  // Arbiter side
  modport slave (
    input  flush_i,
    input  way0_valid_i, way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i, way0_pID_i,
    output way0_ready_o,
    input  way1_valid_i, way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i, way1_pID_i,
    output way1_ready_o,
    output port0_we_o, port0_addr_o, port0_data_o,
    output port1_we_o, port1_addr_o, port1_data_o,
    output expPID_o, err_o
  );

  // WBU / RegFile side
  modport master (
    output flush_i,
    output way0_valid_i, way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i, way0_pID_i,
    input  way0_ready_o,
    output way1_valid_i, way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i, way1_pID_i,
    input  way1_ready_o,
    input  port0_we_o, port0_addr_o, port0_data_o,
    input  port1_we_o, port1_addr_o, port1_data_o,
    input  expPID_o, err_o
  );
endinterface

// File: rtl/wb_commit_arbiter.sv
// In-order write-back commit arbiter: one buffer entry per WBU way, commits
// up to two results per cycle in pID order 00->01->10->11 onto two registered
// RegFile write ports (port0 = older, port1 = younger).
module wb_commit_arbiter (
  input  logic         clk,
  input  logic         reset,
  wb_commit_if.slave   bus
);

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [1:0]  pid;
  } entry_t;

  entry_t      buf_q [2];
  entry_t      buf_d [2];
  entry_t      in_w  [2];
  logic [1:0]  in_valid;
  logic [1:0]  ready;
  logic [1:0]  accept;
  logic [1:0]  parity_bad;
  logic [1:0]  commit;

  logic [1:0]  e_q, e_d;
  logic        err_q, err_d;
  logic        p0_we_q, p0_we_d, p1_we_q, p1_we_d;
  logic [4:0]  p0_addr_q, p0_addr_d, p1_addr_q, p1_addr_d;
  logic [63:0] p0_data_q, p0_data_d, p1_data_q, p1_data_d;

  entry_t      head, second;
  logic        head_sel;
  logic        head_commit, second_commit, waw;

  assign in_w[0]  = {1'b1, bus.way0_rdWriteEnable_i, bus.way0_rdAddr_i, bus.way0_rdData_i, bus.way0_pID_i};
  assign in_w[1]  = {1'b1, bus.way1_rdWriteEnable_i, bus.way1_rdAddr_i, bus.way1_rdData_i, bus.way1_pID_i};
  assign in_valid = {bus.way1_valid_i, bus.way0_valid_i};

  // Select head (way matching e's parity) and the candidate second commit
  always_comb begin
    head_sel      = e_q[0];
    head          = buf_q[head_sel];
    second        = buf_q[~head_sel];
    head_commit   = head.valid && (head.pid == e_q);
    second_commit = head_commit && second.valid && (second.pid == e_q + 2'd1);
    commit        = 2'b00;
    commit[head_sel]  = head_commit;
    commit[~head_sel] = second_commit;
    // Same-cycle write to the same real register: only the younger one lands
    waw = second_commit && head.we && second.we &&
          (head.addr != 5'd0) && (head.addr == second.addr);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      assign ready[gi]      = !buf_q[gi].valid || commit[gi];
      assign accept[gi]     = in_valid[gi] && ready[gi] && !bus.flush_i;
      assign parity_bad[gi] = accept[gi] && (in_w[gi].pid[0] != 1'(gi));
    end
  endgenerate

  assign bus.way0_ready_o = ready[0];
  assign bus.way1_ready_o = ready[1];

  // Next state of buffers, expected pointer, error flag and write ports
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      buf_d[w] = buf_q[w];
      if (bus.flush_i)     buf_d[w].valid = 1'b0;
      else if (accept[w])  buf_d[w] = in_w[w];
      else if (commit[w])  buf_d[w].valid = 1'b0;
    end

    e_d   = bus.flush_i ? 2'd0 : e_q + 2'(head_commit) + 2'(second_commit);
    err_d = bus.flush_i ? 1'b0 : (err_q | (|parity_bad));

    p0_we_d   = 1'b0;
    p0_addr_d = p0_addr_q;
    p0_data_d = p0_data_q;
    p1_we_d   = 1'b0;
    p1_addr_d = p1_addr_q;
    p1_data_d = p1_data_q;
    if (!bus.flush_i && head_commit) begin
      p0_we_d   = head.we && (head.addr != 5'd0) && !waw;
      p0_addr_d = head.addr;
      p0_data_d = head.data;
    end
    if (!bus.flush_i && second_commit) begin
      p1_we_d   = second.we && (second.addr != 5'd0);
      p1_addr_d = second.addr;
      p1_data_d = second.data;
    end
  end

  // State registers; reset drops buffered entries and in-flight port writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < 2; w++) buf_q[w] <= '0;
      e_q       <= 2'd0;
      err_q     <= 1'b0;
      p0_we_q   <= 1'b0;
      p0_addr_q <= 5'd0;
      p0_data_q <= 64'd0;
      p1_we_q   <= 1'b0;
      p1_addr_q <= 5'd0;
      p1_data_q <= 64'd0;
    end else begin
      for (int w = 0; w < 2; w++) buf_q[w] <= buf_d[w];
      e_q       <= e_d;
      err_q     <= err_d;
      p0_we_q   <= p0_we_d;
      p0_addr_q <= p0_addr_d;
      p0_data_q <= p0_data_d;
      p1_we_q   <= p1_we_d;
      p1_addr_q <= p1_addr_d;
      p1_data_q <= p1_data_d;
    end
  end

  assign bus.port0_we_o   = p0_we_q;
  assign bus.port0_addr_o = p0_addr_q;
  assign bus.port0_data_o = p0_data_q;
  assign bus.port1_we_o   = p1_we_q;
  assign bus.port1_addr_o = p1_addr_q;
  assign bus.port1_data_o = p1_data_q;
  assign bus.expPID_o     = e_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed bench for wb_commit_arbiter: paired/out-of-order commits, WAW,
// rd0/we=0 with pID wraparound, flush/parity error and asynchronous reset.
module tb_wb_commit_arbiter;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_commit_if bus();

  wb_commit_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w0(input logic v, input logic we, input logic [4:0] a,
                    input logic [63:0] d, input logic [1:0] p);
    bus.way0_valid_i = v; bus.way0_rdWriteEnable_i = we;
    bus.way0_rdAddr_i = a; bus.way0_rdData_i = d; bus.way0_pID_i = p;
  endtask

  task automatic w1(input logic v, input logic we, input logic [4:0] a,
                    input logic [63:0] d, input logic [1:0] p);
    bus.way1_valid_i = v; bus.way1_rdWriteEnable_i = we;
    bus.way1_rdAddr_i = a; bus.way1_rdData_i = d; bus.way1_pID_i = p;
  endtask

  task automatic idle();
    w0(1'b0, 1'b0, 5'd0, 64'd0, 2'd0);
    w1(1'b0, 1'b0, 5'd0, 64'd0, 2'd1);
  endtask

  task automatic do_reset();
    idle();
    bus.flush_i = 1'b0;
    #2 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.flush_i = 1'b0;
    idle();
    #12;
    $display("reset state");
    chk("rst_p0we", 64'(bus.port0_we_o), 64'd0);
    chk("rst_p1we", 64'(bus.port1_we_o), 64'd0);
    chk("rst_p0addr", 64'(bus.port0_addr_o), 64'd0);
    chk("rst_exp", 64'(bus.expPID_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_rdy0", 64'(bus.way0_ready_o), 64'd1);
    chk("rst_rdy1", 64'(bus.way1_ready_o), 64'd1);

    // Paired commit
    $display("paired commit");
    w0(1'b1, 1'b1, 5'd5, 64'hA, 2'd0);
    w1(1'b1, 1'b1, 5'd6, 64'hB, 2'd1);
    tick();
    idle();
    chk("pair_rdy0", 64'(bus.way0_ready_o), 64'd1);
    chk("pair_rdy1", 64'(bus.way1_ready_o), 64'd1);
    chk("pair_exp_pre", 64'(bus.expPID_o), 64'd0);
    tick();
    chk("pair_p0we", 64'(bus.port0_we_o), 64'd1);
    chk("pair_p0addr", 64'(bus.port0_addr_o), 64'd5);
    chk("pair_p0data", bus.port0_data_o, 64'hA);
    chk("pair_p1we", 64'(bus.port1_we_o), 64'd1);
    chk("pair_p1addr", 64'(bus.port1_addr_o), 64'd6);
    chk("pair_p1data", bus.port1_data_o, 64'hB);
    chk("pair_exp", 64'(bus.expPID_o), 64'd2);
    tick();
    chk("pair_p0we_off", 64'(bus.port0_we_o), 64'd0);
    chk("pair_p1we_off", 64'(bus.port1_we_o), 64'd0);

    // Out-of-order arrival
    $display("out-of-order arrival");
    do_reset();
    tick();
    w1(1'b1, 1'b1, 5'd3, 64'h33, 2'd1);
    tick();
    idle();
    chk("ooo_rdy1_a", 64'(bus.way1_ready_o), 64'd0);
    tick();
    chk("ooo_rdy1_b", 64'(bus.way1_ready_o), 64'd0);
    chk("ooo_p0we_wait", 64'(bus.port0_we_o), 64'd0);
    chk("ooo_p1we_wait", 64'(bus.port1_we_o), 64'd0);
    chk("ooo_exp_wait", 64'(bus.expPID_o), 64'd0);
    w0(1'b1, 1'b1, 5'd4, 64'h44, 2'd0);
    tick();
    idle();
    chk("ooo_rdy1_c", 64'(bus.way1_ready_o), 64'd1);
    tick();
    chk("ooo_p0we", 64'(bus.port0_we_o), 64'd1);
    chk("ooo_p0addr", 64'(bus.port0_addr_o), 64'd4);
    chk("ooo_p0data", bus.port0_data_o, 64'h44);
    chk("ooo_p1we", 64'(bus.port1_we_o), 64'd1);
    chk("ooo_p1addr", 64'(bus.port1_addr_o), 64'd3);
    chk("ooo_exp", 64'(bus.expPID_o), 64'd2);

    // WAW collision
    $display("WAW collision");
    do_reset();
    tick();
    w0(1'b1, 1'b1, 5'd7, 64'd1, 2'd0);
    w1(1'b1, 1'b1, 5'd7, 64'd2, 2'd1);
    tick();
    idle();
    tick();
    chk("waw_p0we", 64'(bus.port0_we_o), 64'd0);
    chk("waw_p1we", 64'(bus.port1_we_o), 64'd1);
    chk("waw_p1addr", 64'(bus.port1_addr_o), 64'd7);
    chk("waw_p1data", bus.port1_data_o, 64'd2);

    // rd0 / we=0 and wraparound
    $display("rd0 / we=0 and wraparound");
    do_reset();
    tick();
    w0(1'b1, 1'b1, 5'd0, 64'h5, 2'd0);
    w1(1'b1, 1'b0, 5'd8, 64'h6, 2'd1);
    tick();
    idle();
    tick();
    chk("rd0_p0we", 64'(bus.port0_we_o), 64'd0);
    chk("rd0_p1we", 64'(bus.port1_we_o), 64'd0);
    chk("rd0_exp", 64'(bus.expPID_o), 64'd2);
    w0(1'b1, 1'b1, 5'd1, 64'h11, 2'd2);
    w1(1'b1, 1'b1, 5'd2, 64'h22, 2'd3);
    tick();
    idle();
    tick();
    chk("wrap_p0we", 64'(bus.port0_we_o), 64'd1);
    chk("wrap_p0addr", 64'(bus.port0_addr_o), 64'd1);
    chk("wrap_p0data", bus.port0_data_o, 64'h11);
    chk("wrap_p1we", 64'(bus.port1_we_o), 64'd1);
    chk("wrap_p1addr", 64'(bus.port1_addr_o), 64'd2);
    chk("wrap_exp", 64'(bus.expPID_o), 64'd0);
    w0(1'b1, 1'b1, 5'd9, 64'h99, 2'd0);
    tick();
    idle();
    tick();
    chk("wrap9_p0we", 64'(bus.port0_we_o), 64'd1);
    chk("wrap9_p0addr", 64'(bus.port0_addr_o), 64'd9);
    chk("wrap9_p0data", bus.port0_data_o, 64'h99);
    chk("wrap9_p1we", 64'(bus.port1_we_o), 64'd0);
    chk("wrap9_exp", 64'(bus.expPID_o), 64'd1);

    // Flush and parity error
    $display("flush and error");
    do_reset();
    tick();
    w1(1'b1, 1'b1, 5'd3, 64'h33, 2'd1);
    tick();
    idle();
    chk("fl_rdy1_held", 64'(bus.way1_ready_o), 64'd0);
    chk("fl_err_pre", 64'(bus.err_o), 64'd0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("fl_rdy1", 64'(bus.way1_ready_o), 64'd1);
    chk("fl_exp", 64'(bus.expPID_o), 64'd0);
    w0(1'b1, 1'b1, 5'd10, 64'hAA, 2'd0);
    tick();
    idle();
    tick();
    chk("fl_p0we", 64'(bus.port0_we_o), 64'd1);
    chk("fl_p0addr", 64'(bus.port0_addr_o), 64'd10);
    chk("fl_p1we", 64'(bus.port1_we_o), 64'd0);
    chk("fl_exp_after", 64'(bus.expPID_o), 64'd1);
    w0(1'b1, 1'b1, 5'd11, 64'hBB, 2'd1);
    tick();
    idle();
    chk("err_set", 64'(bus.err_o), 64'd1);
    tick();
    chk("err_sticky", 64'(bus.err_o), 64'd1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("err_clr", 64'(bus.err_o), 64'd0);
    chk("err_rdy0", 64'(bus.way0_ready_o), 64'd1);

    // Asynchronous reset with both buffers full and port writes in flight
    $display("async reset");
    do_reset();
    tick();
    w0(1'b1, 1'b1, 5'd5, 64'h5, 2'd0);
    w1(1'b1, 1'b1, 5'd6, 64'h6, 2'd1);
    tick();
    w0(1'b1, 1'b1, 5'd12, 64'hC, 2'd0);
    w1(1'b1, 1'b1, 5'd13, 64'hD, 2'd3);
    tick();
    idle();
    chk("ar_p0we_pre", 64'(bus.port0_we_o), 64'd1);
    chk("ar_p1we_pre", 64'(bus.port1_we_o), 64'd1);
    chk("ar_exp_pre", 64'(bus.expPID_o), 64'd2);
    chk("ar_rdy0_pre", 64'(bus.way0_ready_o), 64'd0);
    chk("ar_rdy1_pre", 64'(bus.way1_ready_o), 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("ar_p0we", 64'(bus.port0_we_o), 64'd0);
    chk("ar_p1we", 64'(bus.port1_we_o), 64'd0);
    chk("ar_exp", 64'(bus.expPID_o), 64'd0);
    reset = 1'b0;
    #1;
    chk("ar_rdy0", 64'(bus.way0_ready_o), 64'd1);
    chk("ar_rdy1", 64'(bus.way1_ready_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
